// File: rtl/ram_ctrl_pkg.sv
// Shared types and default sizes for the streaming front-end of the 1024 x 20 RAM.
// The CLEAR state is only reachable when RAM_CTRL_CLEAR_EN is defined.
package ram_ctrl_pkg;

  localparam int DEF_DATA_W = 20;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_LEN_W  = DEF_ADDR_W + 1;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    READ  = 2'd2
  } ctrl_state_t;

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-return path: delays the issue/last flags by two cycles to match the RAM's
// registered-address latency, and registers ram_q into rd_data.
module ram_rd_pipe
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue,
  input  logic              issue_last,
  input  logic [DATA_W-1:0] ram_q,
  output logic              rd_valid,
  output logic              rd_last,
  output logic [DATA_W-1:0] rd_data
);

  logic stage_valid;
  logic stage_last;

  // ram_q for an issued address is valid exactly when stage_valid is high
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= 1'b0;
      stage_last  <= 1'b0;
      rd_valid    <= 1'b0;
      rd_last     <= 1'b0;
      rd_data     <= '0;
    end else begin
      stage_valid <= issue;
      stage_last  <= issue && issue_last;
      rd_valid    <= stage_valid;
      rd_last     <= stage_last;
      if (stage_valid) rd_data <= ram_q;
    end
  end

endmodule

// File: rtl/ram_stream_ctrl.sv
// Owns the single RAM port: arbitrates a write stream against read bursts.
// Define RAM_CTRL_CLEAR_EN to zero the whole RAM after every reset.
module ram_stream_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_cmd_valid,
  input  logic [ADDR_W-1:0] rd_cmd_addr,
  input  logic [ADDR_W:0]   rd_cmd_len,
  output logic              rd_cmd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              busy,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_q
);

  localparam int LEN_W = ADDR_W + 1;

  ctrl_state_t       state, state_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [LEN_W-1:0]  rd_cnt, rd_cnt_nxt;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] data_hold;
  logic              wr_fire;
  logic              issue;
  logic              issue_last;
`ifdef RAM_CTRL_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
`endif

  always_comb begin
    state_nxt    = state;
    rd_addr_nxt  = rd_addr;
    rd_cnt_nxt   = rd_cnt;
    wr_ready     = 1'b0;
    rd_cmd_ready = 1'b0;
    wr_fire      = 1'b0;
    issue        = 1'b0;
    issue_last   = 1'b0;
    busy         = 1'b1;
    ram_we       = 1'b0;
    ram_addr     = addr_hold;
    ram_data     = data_hold;
    case (state)
      IDLE: begin
        busy         = 1'b0;
        rd_cmd_ready = 1'b1;
        wr_ready     = !rd_cmd_valid;
        wr_fire      = wr_valid && !rd_cmd_valid;
        if (wr_fire) begin
          ram_we   = 1'b1;
          ram_addr = wr_ptr;
          ram_data = wr_data;
        end
        // zero-length commands are accepted but start nothing
        if (rd_cmd_valid && (rd_cmd_len != '0)) begin
          rd_addr_nxt = rd_cmd_addr;
          rd_cnt_nxt  = rd_cmd_len;
          state_nxt   = READ;
        end
      end
      READ: begin
        issue       = 1'b1;
        issue_last  = (rd_cnt == LEN_W'(1));
        ram_addr    = rd_addr;
        rd_addr_nxt = rd_addr + 1'b1;
        rd_cnt_nxt  = rd_cnt - 1'b1;
        if (issue_last) state_nxt = IDLE;
      end
`ifdef RAM_CTRL_CLEAR_EN
      CLEAR: begin
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        ram_data = '0;
        if (&clr_addr) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (rst) ram_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef RAM_CTRL_CLEAR_EN
      state    <= CLEAR;
      clr_addr <= '0;
`else
      state    <= IDLE;
`endif
      wr_ptr    <= '0;
      rd_addr   <= '0;
      rd_cnt    <= '0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      state     <= state_nxt;
      rd_addr   <= rd_addr_nxt;
      rd_cnt    <= rd_cnt_nxt;
      addr_hold <= ram_addr;
      data_hold <= ram_data;
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
`ifdef RAM_CTRL_CLEAR_EN
      if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
`endif
    end
  end

  ram_rd_pipe #(.DATA_W(DATA_W)) u_rd_pipe (
    .clk        (clk),
    .rst        (rst),
    .issue      (issue),
    .issue_last (issue_last),
    .ram_q      (ram_q),
    .rd_valid   (rd_valid),
    .rd_last    (rd_last),
    .rd_data    (rd_data)
  );

endmodule

// File: tb/tb_ram_stream_ctrl.sv
// Self-checking bench for ram_stream_ctrl: a behavioural RAM plus a queue-based
// reference of the expected read stream, driven by directed and random traffic.
module tb_ram_stream_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [19:0] wr_data;
  logic        wr_ready;
  logic        rd_cmd_valid;
  logic [9:0]  rd_cmd_addr;
  logic [10:0] rd_cmd_len;
  logic        rd_cmd_ready;
  logic        rd_valid;
  logic [19:0] rd_data;
  logic        rd_last;
  logic [9:0]  wr_ptr;
  logic        busy;
  logic [19:0] ram_data;
  logic [9:0]  ram_addr;
  logic        ram_we;
  logic [19:0] ram_q;

  ram_stream_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_cmd_valid (rd_cmd_valid),
    .rd_cmd_addr  (rd_cmd_addr),
    .rd_cmd_len   (rd_cmd_len),
    .rd_cmd_ready (rd_cmd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .wr_ptr       (wr_ptr),
    .busy         (busy),
    .ram_data     (ram_data),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_q        (ram_q)
  );

  // External single-port RAM with a registered read address
  logic [19:0] ram_mem [0:1023];
  logic [9:0]  ram_addr_q;
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_data;
    ram_addr_q <= ram_addr;
  end
  assign ram_q = ram_mem[ram_addr_q];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          cyc;
    logic [19:0] data;
    bit          known;
    bit          last;
  } exp_t;

  logic [19:0] model_mem [0:1023];
  bit          model_known [0:1023];
  exp_t        expq[$];
  int          wptr;
  int          busy_left;
  int          cyc;
  int          total;
  int          bad;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic checkRead();
    bit exp_v;
    exp_v = (expq.size() > 0) && (expq[0].cyc == cyc);
    checkOutput("rd_valid", {31'd0, rd_valid}, {31'd0, exp_v});
    if (exp_v) begin
      checkOutput("rd_last", {31'd0, rd_last}, {31'd0, expq[0].last});
      if (expq[0].known) checkOutput("rd_data", {12'd0, rd_data}, {12'd0, expq[0].data});
      void'(expq.pop_front());
    end else begin
      checkOutput("rd_last_idle", {31'd0, rd_last}, 32'd0);
    end
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, then advance the model
  task automatic applyStimulus(input bit wv, input logic [19:0] wd, input bit cv, input int ca, input int cl);
    bit   exp_we;
    exp_t e;
    wr_valid     = wv;
    wr_data      = wd;
    rd_cmd_valid = cv;
    rd_cmd_addr  = ca[9:0];
    rd_cmd_len   = cl[10:0];
    @(negedge clk);
    exp_we = (busy_left == 0) && wv && !cv;
    checkOutput("busy", {31'd0, busy}, {31'd0, busy_left > 0});
    checkOutput("rd_cmd_ready", {31'd0, rd_cmd_ready}, {31'd0, busy_left == 0});
    checkOutput("wr_ready", {31'd0, wr_ready}, {31'd0, (busy_left == 0) && !cv});
    checkOutput("wr_ptr", {22'd0, wr_ptr}, wptr);
    checkOutput("ram_we", {31'd0, ram_we}, {31'd0, exp_we});
    if (exp_we) begin
      checkOutput("ram_addr_wr", {22'd0, ram_addr}, wptr);
      checkOutput("ram_data_wr", {12'd0, ram_data}, {12'd0, wd});
    end
    checkRead();
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (exp_we) begin
        model_mem[wptr]   = wd;
        model_known[wptr] = 1'b1;
        wptr = (wptr + 1) % 1024;
      end
      if (cv && cl > 0) begin
        busy_left = cl;
        for (int i = 0; i < cl; i++) begin
          e.cyc   = cyc + 3 + i;
          e.data  = model_mem[(ca + i) % 1024];
          e.known = model_known[(ca + i) % 1024];
          e.last  = (i == cl - 1);
          expq.push_back(e);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic doReset();
    rst          = 1'b1;
    wr_valid     = 1'b0;
    wr_data      = '0;
    rd_cmd_valid = 1'b0;
    rd_cmd_addr  = '0;
    rd_cmd_len   = '0;
    @(negedge clk);
    checkOutput("ram_we_in_reset", {31'd0, ram_we}, 32'd0);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    expq.delete();
    busy_left = 0;
    wptr      = 0;
`ifdef RAM_CTRL_CLEAR_EN
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      checkOutput("clear_busy", {31'd0, busy}, 32'd1);
      checkOutput("clear_wr_ready", {31'd0, wr_ready}, 32'd0);
      checkOutput("clear_cmd_ready", {31'd0, rd_cmd_ready}, 32'd0);
      model_mem[i]   = '0;
      model_known[i] = 1'b1;
      @(posedge clk);
      cyc++;
      #1;
    end
`endif
  endtask

  initial begin
    int r;
    int len;
    total = 0;
    bad   = 0;
    cyc   = 0;
    wptr  = 0;
    busy_left = 0;
    for (int i = 0; i < 1024; i++) model_known[i] = 1'b0;

    $display("[TB] reset state");
    doReset();
    checkOutput("rst_wr_ptr", {22'd0, wr_ptr}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("rst_rd_last", {31'd0, rd_last}, 32'd0);
    checkOutput("rst_rd_data", {12'd0, rd_data}, 32'd0);

    $display("[TB] write 1..4 then read 4");
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 20'(i), 1'b0, 0, 0);
    applyStimulus(1'b0, '0, 1'b1, 0, 4);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b0, 0, 0);

    $display("[TB] 1026 writes with wrap, read across the top");
    doReset();
    for (int i = 0; i < 1026; i++) applyStimulus(1'b1, 20'(i), 1'b0, 0, 0);
    checkOutput("wr_ptr_after_1026", {22'd0, wr_ptr}, 32'd2);
    applyStimulus(1'b0, '0, 1'b1, 1022, 4);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 1'b0, 0, 0);

    $display("[TB] command and write in the same cycle");
    applyStimulus(1'b1, 20'hABCDE, 1'b1, 5, 1);
    applyStimulus(1'b1, 20'hABCDE, 1'b0, 0, 0);
    applyStimulus(1'b1, 20'hABCDE, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 0, 0);

    $display("[TB] zero-length command");
    applyStimulus(1'b0, '0, 1'b1, 7, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, 0, 0);

    $display("[TB] back-to-back bursts");
    applyStimulus(1'b0, '0, 1'b1, 100, 3);
    applyStimulus(1'b0, '0, 1'b0, 0, 0);
    applyStimulus(1'b0, '0, 1'b0, 0, 0);
    applyStimulus(1'b0, '0, 1'b0, 0, 0);
    applyStimulus(1'b0, '0, 1'b1, 1020, 6);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 0, 0);

    $display("[TB] reset in the third cycle of a 16-word burst");
    applyStimulus(1'b0, '0, 1'b1, 0, 16);
    applyStimulus(1'b0, '0, 1'b0, 0, 0);
    applyStimulus(1'b0, '0, 1'b0, 0, 0);
    doReset();
    checkOutput("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    checkOutput("midrst_wr_ptr", {22'd0, wr_ptr}, 32'd0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, '0, 1'b0, 0, 0);

    $display("[TB] random traffic");
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      if (r == 0) len = 0;
      else if (r == 9) len = $urandom_range(0, 64);
      else len = $urandom_range(1, 8);
      applyStimulus(1'($urandom_range(0, 1)), 20'($urandom_range(0, 20'hFFFFF)),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 1023), len);
    end
    for (int i = 0; i < 80; i++) applyStimulus(1'b0, '0, 1'b0, 0, 0);

`ifdef RAM_CTRL_CLEAR_EN
    $display("[TB] clear sweep then full read");
    doReset();
    applyStimulus(1'b0, '0, 1'b1, 0, 1024);
    for (int i = 0; i < 1030; i++) applyStimulus(1'b0, '0, 1'b0, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
